// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory port: RV32I width
// codes, the access FSM states and the base byte-lane strobes.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC0,
    ST_ACC1,
    ST_RESP
  } state_e;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // Unsigned width codes exist only for loads; stores accept SB/SH/SW.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core request/response handshake plus the word-wide data-memory port.
interface lsu_mem_port_if #(
  parameter int Depth = 128
);
  localparam int AW = $clog2(Depth);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_we0;
  logic [AW-1:0] mem_wr_addr0;
  logic [AW-1:0] mem_rd_addr0;
  logic [3:0]    mem_wr_strb;
  logic [3:0]    mem_rd_strb;
  logic [31:0]   mem_wr_din0;
  logic [31:0]   mem_rd_dout0;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_dout0,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we0, mem_wr_addr0, mem_rd_addr0, mem_wr_strb, mem_rd_strb, mem_wr_din0
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_dout0,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_we0, mem_wr_addr0, mem_rd_addr0, mem_wr_strb, mem_rd_strb, mem_wr_din0
  );

endinterface

// File: rtl/lsu_mem_port_align.sv
// Combinational lane logic: strobes, write-data placement, read merge and
// sign/zero extension for one (possibly word-crossing) access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        hi_phase,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [3:0]  strb,
  output logic [31:0] wr_data,
  output logic        crossing,
  output logic [31:0] rdata
);

  logic [3:0]  base;
  logic [7:0]  strb_wide;
  logic [63:0] wr_wide;
  logic [31:0] raw;

  always_comb begin
    case (funct3[1:0])
      2'd0:    base = STRB_B;
      2'd1:    base = STRB_H;
      default: base = STRB_W;
    endcase

    // Upper nibble / upper word hold the part that spills into the next word.
    strb_wide = {4'b0000, base} << off;
    crossing  = |strb_wide[7:4];
    strb      = hi_phase ? strb_wide[7:4] : strb_wide[3:0];

    wr_wide = {32'h0, wdata} << {off, 3'b000};
    wr_data = hi_phase ? wr_wide[63:32] : wr_wide[31:0];

    raw = 32'({rd_hi, rd_lo} >> {off, 3'b000});

    case (funct3)
      F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   rdata = {24'h0, raw[7:0]};
      F3_HU:   rdata = {16'h0, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one request at a time, misaligned accesses
// split into two word accesses, single-cycle response pulse.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int Depth = 128,
  parameter int Width = 32
) (
  input  logic          clk,
  input  logic          reset,
  lsu_mem_port_if.slave bus
);

  localparam int AW = $clog2(Depth);

  state_e           state_reg, state_next;
  logic             we_reg, we_next;
  logic [2:0]       f3_reg, f3_next;
  logic [1:0]       off_reg, off_next;
  logic [AW-1:0]    word_reg, word_next;
  logic [Width-1:0] wdata_reg, wdata_next;
  logic [Width-1:0] rd_lo_reg, rd_lo_next;
  logic [Width-1:0] rd_hi_reg, rd_hi_next;
  logic             err_reg, err_next;

  logic             in_acc;
  logic             hi_phase;
  logic [AW-1:0]    word_inc;
  logic [AW-1:0]    word_acc;
  logic [3:0]       align_strb;
  logic [31:0]      align_wr;
  logic [31:0]      align_rdata;
  logic             crossing;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:AW+2];

  lsu_align u_align (
    .funct3   (f3_reg),
    .off      (off_reg),
    .hi_phase (hi_phase),
    .wdata    (wdata_reg),
    .rd_lo    (rd_lo_reg),
    .rd_hi    (rd_hi_reg),
    .strb     (align_strb),
    .wr_data  (align_wr),
    .crossing (crossing),
    .rdata    (align_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      f3_reg    <= 3'd0;
      off_reg   <= 2'd0;
      word_reg  <= '0;
      wdata_reg <= '0;
      rd_lo_reg <= '0;
      rd_hi_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      f3_reg    <= f3_next;
      off_reg   <= off_next;
      word_reg  <= word_next;
      wdata_reg <= wdata_next;
      rd_lo_reg <= rd_lo_next;
      rd_hi_reg <= rd_hi_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    f3_next    = f3_reg;
    off_next   = off_reg;
    word_next  = word_reg;
    wdata_next = wdata_reg;
    rd_lo_next = rd_lo_reg;
    rd_hi_next = rd_hi_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_next    = bus.req_we;
          f3_next    = bus.req_funct3;
          off_next   = bus.req_addr[1:0];
          word_next  = bus.req_addr[AW+1:2];
          wdata_next = bus.req_wdata;
          // Cleared so an aligned access merges with zero in the upper half.
          rd_lo_next = '0;
          rd_hi_next = '0;
          err_next   = !f3_legal(bus.req_we, bus.req_funct3);
          state_next = f3_legal(bus.req_we, bus.req_funct3) ? ST_ACC0 : ST_RESP;
        end
      end
      ST_ACC0: begin
        rd_lo_next = bus.mem_rd_dout0;
        state_next = crossing ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        rd_hi_next = bus.mem_rd_dout0;
        state_next = ST_RESP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign in_acc   = (state_reg == ST_ACC0) || (state_reg == ST_ACC1);
  assign hi_phase = (state_reg == ST_ACC1);
  assign word_inc = (word_reg == AW'(Depth - 1)) ? '0 : word_reg + 1'b1;
  assign word_acc = hi_phase ? word_inc : word_reg;

  assign bus.req_ready    = (state_reg == ST_IDLE);
  assign bus.rsp_valid    = (state_reg == ST_RESP);
  assign bus.rsp_err      = (state_reg == ST_RESP) && err_reg;
  assign bus.rsp_rdata    = ((state_reg == ST_RESP) && !we_reg && !err_reg) ? align_rdata : '0;
  assign bus.mem_we0      = in_acc && we_reg;
  assign bus.mem_wr_addr0 = in_acc ? word_acc : '0;
  assign bus.mem_rd_addr0 = in_acc ? word_acc : '0;
  assign bus.mem_wr_strb  = in_acc ? align_strb : 4'b0000;
  assign bus.mem_rd_strb  = in_acc ? align_strb : 4'b0000;
  assign bus.mem_wr_din0  = in_acc ? align_wr : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised bench for lsu_mem_port: byte-level reference model feeding a
// per-cycle expectation queue, plus directed literal cases and reset checks.
module tb_lsu_mem_port;

  localparam int Depth = 128;
  localparam int AW    = $clog2(Depth);

  typedef struct {
    logic          ready;
    logic          acc;
    logic          we;
    logic [3:0]    strb;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic          rvalid;
    logic          err;
    logic [31:0]   rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.Depth(Depth)) bus ();

  lsu_mem_port #(.Depth(Depth), .Width(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0]   mem   [Depth];
  logic [7:0]    ref_b [4*Depth];
  exp_t          exp_q [$];
  exp_t          cur_e;
  logic          chk_en = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [3:0]    s_strb [4];
  logic [AW-1:0] s_addr [4];
  int            s_rcyc;
  logic [31:0]   s_rdata;
  logic          s_err;

  // Memory model: combinational masked read, strobed write on the clock edge.
  always_comb begin
    bus.mem_rd_dout0 = '0;
    for (int l = 0; l < 4; l++)
      if (bus.mem_rd_strb[l]) bus.mem_rd_dout0[8*l +: 8] = mem[bus.mem_rd_addr0][8*l +: 8];
  end

  always @(posedge clk) begin
    if (bus.mem_we0)
      for (int l = 0; l < 4; l++)
        if (bus.mem_wr_strb[l]) mem[bus.mem_wr_addr0][8*l +: 8] <= bus.mem_wr_din0[8*l +: 8];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e.ready = 1'b1; e.acc = 1'b0; e.we = 1'b0; e.strb = 4'b0000; e.addr = '0;
    e.din = '0; e.rvalid = 1'b0; e.err = 1'b0; e.rdata = '0;
    return e;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) if (s[l]) m[8*l +: 8] = 8'hFF;
    return m;
  endfunction

  // Byte-level view of an access: which lanes of which words it touches,
  // and the value it reads or the bytes it writes.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output int ncyc);
    exp_t e;
    int n, off, k, ba, bi;
    logic [31:0] v;
    logic legal;
    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && (f3 == 3'd4 || f3 == 3'd5)));
    e = idle_e();
    exp_q.push_back(e);
    if (!legal) begin
      e = idle_e(); e.ready = 1'b0; e.rvalid = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
      ncyc = 1;
      return;
    end
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ba  = int'(addr % (4 * Depth));
    off = ba % 4;
    k   = (n < 4 - off) ? n : 4 - off;
    e = idle_e(); e.ready = 1'b0; e.acc = 1'b1; e.we = we; e.addr = AW'(ba / 4);
    for (int i = 0; i < k; i++) begin
      e.strb[off+i] = 1'b1;
      e.din[8*(off+i) +: 8] = wdata[8*i +: 8];
    end
    exp_q.push_back(e);
    ncyc = 1;
    if (n > k) begin
      e = idle_e(); e.ready = 1'b0; e.acc = 1'b1; e.we = we; e.addr = AW'((ba / 4 + 1) % Depth);
      for (int j = 0; j < n - k; j++) begin
        e.strb[j] = 1'b1;
        e.din[8*j +: 8] = wdata[8*(k+j) +: 8];
      end
      exp_q.push_back(e);
      ncyc = 2;
    end
    v = '0;
    for (int i = 0; i < n; i++) begin
      bi = (ba + i) % (4 * Depth);
      if (we) ref_b[bi] = wdata[8*i +: 8];
      else    v[8*i +: 8] = ref_b[bi];
    end
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    e = idle_e(); e.ready = 1'b0; e.rvalid = 1'b1; e.rdata = we ? 32'h0 : v;
    exp_q.push_back(e);
    ncyc = ncyc + 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cur_e = idle_e();
      if (exp_q.size() > 0) cur_e = exp_q.pop_front();
      check("req_ready", 32'(bus.req_ready), 32'(cur_e.ready));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(cur_e.rvalid));
      check("rsp_err", 32'(bus.rsp_err & bus.rsp_valid), 32'(cur_e.err));
      check("mem_we0", 32'(bus.mem_we0), 32'(cur_e.we));
      check("mem_wr_strb", 32'(bus.mem_wr_strb), 32'(cur_e.strb));
      check("mem_rd_strb", 32'(bus.mem_rd_strb), 32'(cur_e.strb));
      if (cur_e.rvalid) check("rsp_rdata", bus.rsp_rdata, cur_e.rdata);
      if (cur_e.acc) begin
        check("mem_wr_addr0", 32'(bus.mem_wr_addr0), 32'(cur_e.addr));
        check("mem_rd_addr0", 32'(bus.mem_rd_addr0), 32'(cur_e.addr));
        check("mem_wr_din0", bus.mem_wr_din0 & lane_mask(cur_e.strb), cur_e.din);
      end
    end
  end

  // Issue one request in an idle cycle; junk is driven while the block is busy.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    model_req(we, f3, addr, wdata, n);
    s_rcyc = -1; s_rdata = '0; s_err = 1'b0;
    for (int c = 0; c < 4; c++) begin s_strb[c] = '0; s_addr[c] = '0; end
    @(negedge clk);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_we     = 1'($urandom_range(0, 1));
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      @(negedge clk);
      s_strb[c] = bus.mem_wr_strb;
      s_addr[c] = bus.mem_wr_addr0;
      if (bus.rsp_valid && s_rcyc < 0) begin
        s_rcyc = c; s_rdata = bus.rsp_rdata; s_err = bus.rsp_err;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    $display("req we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rsp@T+%0d err=%0d rdata=0x%08h",
             we, f3, addr, wdata, s_rcyc, s_err, s_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < Depth; w++) mem[w] = $urandom;
    mem[0] = 32'h11223344;
    mem[1] = 32'hA5B6C7D8;
    for (int w = 0; w < Depth; w++)
      for (int l = 0; l < 4; l++) ref_b[4*w+l] = mem[w][8*l +: 8];
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_mem_we0", 32'(bus.mem_we0), 32'd0);
    check("reset_strb", 32'({bus.mem_wr_strb, bus.mem_rd_strb}), 32'd0);
    check("reset_addr", 32'({bus.mem_wr_addr0, bus.mem_rd_addr0}), 32'd0);
    check("reset_din", bus.mem_wr_din0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    do_req(1'b0, 3'd0, 32'd4, 32'd0);
    check("lb_rdata", s_rdata, 32'hFFFFFFD8);
    check("lb_latency", 32'(s_rcyc), 32'd2);
    do_req(1'b0, 3'd4, 32'd4, 32'd0);
    check("lbu_rdata", s_rdata, 32'h000000D8);
    do_req(1'b0, 3'd1, 32'd2, 32'd0);
    check("lh_rdata", s_rdata, 32'h00001122);
    do_req(1'b0, 3'd2, 32'd2, 32'd0);
    check("lw_x_strb0", 32'(s_strb[1]), 32'b1100);
    check("lw_x_strb1", 32'(s_strb[2]), 32'b0011);
    check("lw_x_rdata", s_rdata, 32'hC7D81122);
    check("lw_x_latency", 32'(s_rcyc), 32'd3);
    do_req(1'b1, 3'd1, 32'd3, 32'h0000BEEF);
    check("sh_x_strb0", 32'(s_strb[1]), 32'b1000);
    check("sh_x_strb1", 32'(s_strb[2]), 32'b0001);
    check("sh_x_word0", mem[0], 32'hEF223344);
    check("sh_x_word1", mem[1], 32'hA5B6C7BE);
    do_req(1'b0, 3'd2, 32'(4 * (Depth - 1) + 1), 32'd0);
    check("wrap_addr0", 32'(s_addr[1]), 32'(Depth - 1));
    check("wrap_addr1", 32'(s_addr[2]), 32'd0);
    do_req(1'b0, 3'd3, 32'd8, 32'd0);
    check("illegal_latency", 32'(s_rcyc), 32'd1);
    check("illegal_err", 32'(s_err), 32'd1);

    // Reset arriving during the second half of a crossing load.
    chk_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'd6;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_acc1_strb", 32'(bus.mem_rd_strb), 32'b0011);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mid_strb", 32'({bus.mem_wr_strb, bus.mem_rd_strb}), 32'd0);
    check("rst_mid_we", 32'(bus.mem_we0), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_no_late_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    repeat (300) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      do_req(r_we, r_f3, r_addr, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
